// File: rtl/aes_keysched_lanes.sv
// AES-128 single-step round-key generator sharing an external byte S-box over SBOX_LANES lanes.
// Define KEYSCHED_INVERSE_EN to add inverse (round r -> r-1) expansion selected by dir_i.
module aes_keysched_lanes #(
  parameter int SBOX_LANES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic                    dir_i,
  input  logic [3:0]              round_i,
  input  logic [127:0]            last_key_i,
  output logic [127:0]            new_key_o,
  output logic                    ready_o,
  output logic                    busy_o,
  output logic                    sbox_access_o,
  output logic [8*SBOX_LANES-1:0] sbox_data_o,
  input  logic [8*SBOX_LANES-1:0] sbox_data_i,
  output logic                    sbox_decrypt_o
);
  localparam int         NBEATS = 4 / SBOX_LANES;
  localparam logic [2:0] LAST_C = 3'(NBEATS);

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("aes_keysched_lanes: SBOX_LANES must be 1, 2 or 4");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_SUB = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     round_q, round_d;
  logic [31:0]    sub_q, sub_d;
  logic [127:0]   new_key_q, new_key_d;
  logic           ready_q, ready_d;
`ifdef KEYSCHED_INVERSE_EN
  logic           dir_q, dir_d;
`else
  logic           unused_dir_s;
  assign unused_dir_s = dir_i;
`endif

  logic [127:0]   src_key_s;
  logic [31:0]    rot_s;
  logic           access_s;
  logic [31:0]    sub_full_s;
  logic [127:0]   w_s;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // S-box request: beat 0 comes straight from the inputs in the start cycle, later beats from the captured key
  always_comb begin
    logic [31:0] t;
    logic [1:0]  idx;
    int          beat;
    src_key_s = (state_q == ST_IDLE) ? last_key_i : key_q;
`ifdef KEYSCHED_INVERSE_EN
    if (((state_q == ST_IDLE) ? dir_i : dir_q) == 1'b1) begin
      t = src_key_s[31:0] ^ src_key_s[63:32];
    end else begin
      t = src_key_s[31:0];
    end
`else
    t = src_key_s[31:0];
`endif
    rot_s = rot_word(t);
    if (reset) begin
      access_s = 1'b0;
    end else if (state_q == ST_IDLE) begin
      access_s = start_i;
    end else begin
      access_s = (cnt_q != LAST_C);
    end
    beat = (state_q == ST_SUB) ? int'(cnt_q) : 0;
    sbox_data_o = {(8*SBOX_LANES){1'b0}};
    for (int l = 0; l < SBOX_LANES; l++) begin
      idx = 2'(beat * SBOX_LANES + l);
      sbox_data_o[8*l +: 8] = access_s ? 8'(rot_s >> {~idx, 3'b000}) : 8'h00;
    end
  end

  // Merge the returning S-box bytes into the substituted word and form the candidate round key
  always_comb begin
    logic [1:0]  pos;
    logic [4:0]  sh;
    logic [31:0] x;
    logic [31:0] w0, w1, w2, w3;
    sub_full_s = sub_q;
    for (int l = 0; l < SBOX_LANES; l++) begin
      pos = 2'((int'(cnt_q) - 1) * SBOX_LANES + l);
      sh  = {~pos, 3'b000};
      sub_full_s = (state_q == ST_SUB)
                 ? ((sub_full_s & ~(32'h0000_00ff << sh)) | ({24'h00_0000, sbox_data_i[8*l +: 8]} << sh))
                 : sub_full_s;
    end
    x  = sub_full_s ^ {rcon(round_q), 24'h00_0000};
    w0 = key_q[127:96] ^ x;
    w1 = w0 ^ key_q[95:64];
    w2 = w1 ^ key_q[63:32];
    w3 = w2 ^ key_q[31:0];
    w_s = {w0, w1, w2, w3};
`ifdef KEYSCHED_INVERSE_EN
    if (dir_q) begin
      w_s = {key_q[127:96] ^ x,
             key_q[95:64] ^ key_q[127:96],
             key_q[63:32] ^ key_q[95:64],
             key_q[31:0]  ^ key_q[63:32]};
    end else begin
      w_s = {w0, w1, w2, w3};
    end
`endif
  end

  // Next-state logic: capture on start, one beat per cycle in SUB, publish the key when leaving SUB
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    round_d   = round_q;
    sub_d     = sub_q;
    new_key_d = new_key_q;
    ready_d   = 1'b0;
`ifdef KEYSCHED_INVERSE_EN
    dir_d     = dir_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SUB;
          cnt_d   = 3'd1;
          key_d   = last_key_i;
          round_d = round_i;
          sub_d   = 32'h0000_0000;
`ifdef KEYSCHED_INVERSE_EN
          dir_d   = dir_i;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SUB: begin
        sub_d = sub_full_s;
        if (cnt_q == LAST_C) begin
          state_d   = ST_IDLE;
          cnt_d     = 3'd0;
          new_key_d = w_s;
          ready_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      key_q     <= 128'h0;
      round_q   <= 4'd0;
      sub_q     <= 32'h0000_0000;
      new_key_q <= 128'h0;
      ready_q   <= 1'b0;
`ifdef KEYSCHED_INVERSE_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      round_q   <= round_d;
      sub_q     <= sub_d;
      new_key_q <= new_key_d;
      ready_q   <= ready_d;
`ifdef KEYSCHED_INVERSE_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign new_key_o      = new_key_q;
  assign ready_o        = ready_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign sbox_access_o  = access_s;
  assign sbox_decrypt_o = 1'b0;

endmodule

// File: tb/tb_aes_keysched_lanes.sv
// Scoreboard bench for aes_keysched_lanes: one DUT per lane setting, each with its own S-box responder,
// stimulus process and monitor, checked against a word-level AES key-expansion model.
module tb_aes_keysched_lanes;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int done_cnt = 0;

  logic [7:0] sbox_tbl [256];

  typedef struct packed {
    logic [127:0] k;
    logic [31:0]  c;
  } exp_t;

  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  task automatic chk(input int lanes, input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL lanes=%0d %s: got %h, want %h", lanes, nm, act, exp);
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_f(input logic [3:0] r);
    logic [7:0] c = 8'h01;
    if (r < 4'd1 || r > 4'd10) return 8'h00;
    for (int i = 1; i < int'(r); i++) c = xtime(c);
    return c;
  endfunction

  // One AES-128 key-schedule step in either direction
  function automatic logic [127:0] exp_next(input logic [127:0] k, input logic [3:0] r, input logic d);
    logic inv;
    logic [31:0] k0, k1, k2, k3, t, n0, n1, n2, n3;
`ifdef KEYSCHED_INVERSE_EN
    inv = d;
`else
    inv = d & 1'b0;
`endif
    {k0, k1, k2, k3} = k;
    if (!inv) begin
      t  = sub_word({k3[23:0], k3[31:24]}) ^ {rcon_f(r), 24'h000000};
      n0 = k0 ^ t; n1 = n0 ^ k1; n2 = n1 ^ k2; n3 = n2 ^ k3;
    end else begin
      n3 = k3 ^ k2; n2 = k2 ^ k1; n1 = k1 ^ k0;
      n0 = k0 ^ sub_word({n3[23:0], n3[31:24]}) ^ {rcon_f(r), 24'h000000};
    end
    return {n0, n1, n2, n3};
  endfunction

  // AES S-box from the GF(2^8) inverse and affine map
  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam int N = 4 / L;

    logic rst, start, dir, rdy, busy, acc, sdec;
    logic [3:0] rnd;
    logic [127:0] key, nkey;
    logic [8*L-1:0] sdo;
    logic [8*L-1:0] sdi = '0;
    int cyc = 0;
    exp_t q[$];
    exp_t e;

    aes_keysched_lanes #(.SBOX_LANES(L)) u_dut (
      .clk(clk), .reset(rst), .start_i(start), .dir_i(dir), .round_i(rnd),
      .last_key_i(key), .new_key_o(nkey), .ready_o(rdy), .busy_o(busy),
      .sbox_access_o(acc), .sbox_data_o(sdo), .sbox_data_i(sdi), .sbox_decrypt_o(sdec)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
      for (int l = 0; l < L; l++) sdi[8*l +: 8] <= sbox_tbl[sdo[8*l +: 8]];
    end

    always @(negedge clk) begin
      chk(L, "sbox_decrypt", 128'(sdec), 128'h0);
      if (!rst && rdy) begin
        if (q.size() == 0) begin
          chk(L, "unexpected_ready", 128'(rdy), 128'h0);
        end else begin
          e = q.pop_front();
          chk(L, "new_key", nkey, e.k);
          chk(L, "ready_cycle", 128'(cyc), 128'(e.c));
        end
      end
    end

    task automatic issue(input logic [127:0] k, input logic [3:0] r, input logic d);
      start = 1'b1; key = k; rnd = r; dir = d;
      q.push_back('{k: exp_next(k, r, d), c: 32'(cyc + 1 + N)});
      @(negedge clk);
      start = 1'b0;
    endtask

    task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); #1;
        if (q.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        chk(L, "completion_timeout", 128'(q.size()), 128'h0);
        q.delete();
      end
    endtask

    initial begin
      logic [127:0] k;
      logic [31:0] rw;
      logic [8*L-1:0] want;
      logic [3:0] r;
      bit found;
      rst = 1'b1; start = 1'b0; dir = 1'b0; rnd = 4'd0; key = 128'h0;
      repeat (3) @(negedge clk);
      chk(L, "rst_new_key", nkey, 128'h0);
      chk(L, "rst_ready", 128'(rdy), 128'h0);
      chk(L, "rst_busy", 128'(busy), 128'h0);
      chk(L, "rst_access", 128'(acc), 128'h0);
      chk(L, "rst_sbox_data", 128'(sdo), 128'h0);
      rst = 1'b0;
      @(negedge clk);
      chk(L, "idle_access", 128'(acc), 128'h0);

      // Round 1 from the FIPS-197 key, watching every S-box beat
      rw = {FIPS_K0[23:0], FIPS_K0[31:24]};
      start = 1'b1; key = FIPS_K0; rnd = 4'd1; dir = 1'b0;
      q.push_back('{k: exp_next(FIPS_K0, 4'd1, 1'b0), c: 32'(cyc + 1 + N)});
      for (int b = 0; b <= N; b++) begin
        if (b > 0) begin @(negedge clk); start = 1'b0; end
        #1;
        if (b < N) begin
          for (int l = 0; l < L; l++) want[8*l +: 8] = rw[31 - 8*(b*L + l) -: 8];
          chk(L, "beat_access", 128'(acc), 128'h1);
          chk(L, "beat_sbox_data", 128'(sdo), 128'(want));
        end else begin
          chk(L, "capture_beat_access", 128'(acc), 128'h0);
        end
      end
      wait_idle();
      chk(L, "fips_round1", nkey, FIPS_K1);

      k = FIPS_K1;
      for (int i = 2; i <= 10; i++) begin
        issue(k, 4'(i), 1'b0);
        wait_idle();
        if (i == 2) chk(L, "fips_round2", nkey, FIPS_K2);
        if (i == 10) chk(L, "fips_round10", nkey, FIPS_K10);
        k = exp_next(k, 4'(i), 1'b0);
      end

`ifdef KEYSCHED_INVERSE_EN
      k = FIPS_K10;
      for (int i = 10; i >= 1; i--) begin
        issue(k, 4'(i), 1'b1);
        wait_idle();
        if (i == 10) chk(L, "inv_round10", nkey, FIPS_K9);
        k = exp_next(k, 4'(i), 1'b1);
      end
      chk(L, "inv_round1", nkey, FIPS_K0);
`endif

      // Inputs wiggling and start pulsed while busy
      issue(FIPS_K0, 4'd1, 1'b0);
      repeat (N) begin
        key = {$urandom, $urandom, $urandom, $urandom};
        rnd = 4'($urandom_range(0, 15));
        start = 1'b1;
        @(negedge clk);
      end
      start = 1'b0;
      wait_idle();
      chk(L, "stable_inputs", nkey, FIPS_K1);
      repeat (N + 3) @(negedge clk);
      chk(L, "no_second_op", 128'(busy), 128'h0);

      // Start in the completion cycle
      issue(FIPS_K1, 4'd2, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rdy) begin found = 1'b1; break; end
      end
      chk(L, "b2b_first_ready", 128'(found), 128'h1);
      issue(FIPS_K2, 4'd3, 1'b0);
      wait_idle();

      // Reset while in SUB
      start = 1'b1; key = {$urandom, $urandom, $urandom, $urandom}; rnd = 4'd5; dir = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (N >= 2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk(L, "midrst_access", 128'(acc), 128'h0);
      chk(L, "midrst_busy", 128'(busy), 128'h0);
      chk(L, "midrst_new_key", nkey, 128'h0);
      chk(L, "midrst_ready", 128'(rdy), 128'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (N + 3) @(negedge clk);
      issue(FIPS_K0, 4'd1, 1'b0);
      wait_idle();
      chk(L, "after_reset_key", nkey, FIPS_K1);

      // Random keys, rounds (including out-of-range ones) and directions
      for (int i = 0; i < 24; i++) begin
        r = (i == 0) ? 4'd0 : (i == 1) ? 4'd11 : (i == 2) ? 4'd15 : 4'($urandom_range(0, 15));
        issue({$urandom, $urandom, $urandom, $urandom}, r, 1'($urandom_range(0, 1)));
        key = {$urandom, $urandom, $urandom, $urandom};
        wait_idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      done_cnt++;
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (done_cnt == 3) break;
    end
    if (done_cnt != 3) chk(0, "global_timeout", 128'(done_cnt), 128'd3);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
